word_unpack: RTL and testbench

- Downstream consumer of the 64-bit serialiser stream. Takes a command carrying a word count, accepts that many 64-bit words on the standard isReady/canReceive bus, and emits each word as 64/ELEM_BITS elements, least-significant lane first.
- Feeds the per-coefficient arithmetic (16-bit matrix entries in the default configuration).
- Sustains one element per cycle with back-to-back words and no bubble at word boundaries.

---
 rtl/word_unpack.sv | 60 ++++++
 tb/tb_word_unpack.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/word_unpack.sv
// word_unpack: splits counted 64-bit words into 64/ELEM_BITS elements, LSB lane first.
// Define WORD_UNPACK_BYPASS_EN to send lane 0 of a word straight out in its acceptance cycle.
module word_unpack #(
  parameter int MAX_WORDS = 1,
  parameter int ELEM_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_start,
  input  logic [$clog2(MAX_WORDS+1)-1:0] cmd_numWords,
  output logic                           cmd_canReceive,
  input  logic [63:0]                    in,
  input  logic                           in_isReady,
  output logic                           in_canReceive,
  output logic [ELEM_BITS-1:0]           out,
  output logic                           out_isReady,
  input  logic                           out_canReceive,
  output logic                           out_isLast
);
  localparam int LANES = 64 / ELEM_BITS;
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int LW = $clog2(LANES + 1);
  logic [CW-1:0] words_q, words_d, words_eff;
  logic [LW-1:0] lanes_q, lanes_d;
  logic [63:0]   buf_q, buf_d;
  logic          cmd_acc, in_take, shift, bypass;
  assign cmd_canReceive = (words_q == '0) && (lanes_q == '0);
  assign cmd_acc        = cmd_start && cmd_canReceive;
  assign words_eff      = cmd_acc ? cmd_numWords : words_q;
  assign shift          = (lanes_q != '0) && out_canReceive;
`ifdef WORD_UNPACK_BYPASS_EN
  assign in_canReceive = (words_eff != '0) && out_canReceive && (lanes_q <= LW'(1));
  assign bypass        = in_take && (lanes_q == '0);
`else
  assign in_canReceive = (words_eff != '0) && ((lanes_q == '0) || ((lanes_q == LW'(1)) && out_canReceive));
  assign bypass        = 1'b0;
`endif
  assign in_take     = in_isReady && in_canReceive;
  assign out_isReady = shift || bypass;
  assign out         = bypass ? in[ELEM_BITS-1:0] : buf_q[ELEM_BITS-1:0];
  assign out_isLast  = (shift && (lanes_q == LW'(1)) && (words_q == '0)) ||
                       (bypass && (LANES == 1) && (words_eff == CW'(1)));
  // A word load wins over the shift that drains the previous word's final lane.
  always_comb begin
    words_d = in_take ? words_eff - CW'(1) : words_eff;
    lanes_d = in_take ? (bypass ? LW'(LANES - 1) : LW'(LANES)) : shift ? lanes_q - LW'(1) : lanes_q;
    buf_d   = in_take ? (bypass ? in >> ELEM_BITS : in) : shift ? buf_q >> ELEM_BITS : buf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      lanes_q <= '0;
      buf_q   <= '0;
    end else begin
      words_q <= words_d;
      lanes_q <= lanes_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_word_unpack.sv
// tb_word_unpack: directed checks of word_unpack (MAX_WORDS=4, ELEM_BITS=16).
module tb_word_unpack;
`ifdef WORD_UNPACK_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 0, rst = 1, cmd_start = 0, in_isReady = 0, out_canReceive = 1;
  logic [2:0]  cmd_numWords = '0;
  logic [63:0] in_w = '0;
  logic        cmd_canReceive, in_canReceive, out_isReady, out_isLast;
  logic [15:0] out_e;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] wds [4];
  logic [15:0] got [$];
  int          gcyc [$];
  bit          glast [$];
  int          in_pulses, viol, done_cyc, last_cyc;

  always #5 clk = ~clk;

  word_unpack #(.MAX_WORDS(4), .ELEM_BITS(16)) u_dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_numWords(cmd_numWords),
    .cmd_canReceive(cmd_canReceive), .in(in_w), .in_isReady(in_isReady),
    .in_canReceive(in_canReceive), .out(out_e), .out_isReady(out_isReady),
    .out_canReceive(out_canReceive), .out_isLast(out_isLast));

`ifdef WORD_UNPACK_BYPASS_EN
  logic        b_cmd_start = 0, b_in_isReady = 0, b_out_canReceive = 1;
  logic [2:0]  b_numWords = '0;
  logic [63:0] b_in = '0;
  logic        b_cmd_can, b_in_can, b_out_rdy, b_out_last;
  logic [31:0] b_out;
  word_unpack #(.MAX_WORDS(4), .ELEM_BITS(32)) u_byp (
    .clk(clk), .rst(rst), .cmd_start(b_cmd_start), .cmd_numWords(b_numWords),
    .cmd_canReceive(b_cmd_can), .in(b_in), .in_isReady(b_in_isReady),
    .in_canReceive(b_in_can), .out(b_out), .out_isReady(b_out_rdy),
    .out_canReceive(b_out_canReceive), .out_isLast(b_out_last));
`endif

  // Drives one command; entered and left just after a rising edge.
  task automatic run(input int nw, input int mode, input bit poke);
    int sent = 0;
    got.delete(); gcyc.delete(); glast.delete();
    in_pulses = 0; viol = 0; done_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      cmd_start      = (c == 0) || (poke && c == 2);
      cmd_numWords   = (c == 0) ? 3'(nw) : 3'd3;
      out_canReceive = (mode == 0) || (c % 3 == 0);
      #1;
      in_isReady = in_canReceive && (sent < nw);
      in_w       = (sent < nw) ? wds[sent] : '0;
      @(negedge clk);
      if (!out_canReceive && (sent * 4 - got.size()) > 1 && in_canReceive) viol++;
      if (in_isReady) begin in_pulses++; sent++; end
      if (out_isReady) begin
        got.push_back(out_e); gcyc.push_back(c); glast.push_back(out_isLast);
        if (out_isLast) last_cyc = c;
      end
      if (cmd_canReceive && (nw == 0 ? c >= 1 : (last_cyc >= 0 && c > last_cyc))) done_cyc = c;
      @(posedge clk); #1;
    end
    cmd_start = 0; in_isReady = 0; out_canReceive = 1; in_w = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_cmp += 5;
    if (cmd_canReceive !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_can got %b want 1", cmd_canReceive); end
    if (in_canReceive !== 1'b0) begin n_bad++; $display("FAIL reset_in_can got %b want 0", in_canReceive); end
    if (out_isReady !== 1'b0) begin n_bad++; $display("FAIL reset_out_rdy got %b want 0", out_isReady); end
    if (out_isLast !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_isLast); end
    if (out_e !== 16'h0) begin n_bad++; $display("FAIL reset_out got %h want 0000", out_e); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    wds[0] = 64'h4444_3333_2222_1111;
    run(1, 0, 0);
    n_cmp += 3;
    if (got.size() != 4) begin n_bad++; $display("FAIL single_count got %0d want 4", got.size()); end
    if (in_pulses != 1) begin n_bad++; $display("FAIL single_words got %0d want 1", in_pulses); end
    if (done_cyc != LAT + 4) begin n_bad++; $display("FAIL single_done got %0d want %0d", done_cyc, LAT + 4); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp += 3;
      if (got[i] !== 16'(16'h1111 * (i + 1))) begin n_bad++; $display("FAIL single_val[%0d] got %h want %h", i, got[i], 16'(16'h1111 * (i + 1))); end
      if (gcyc[i] != LAT + i) begin n_bad++; $display("FAIL single_cyc[%0d] got %0d want %0d", i, gcyc[i], LAT + i); end
      if (glast[i] != (i == 3)) begin n_bad++; $display("FAIL single_last[%0d] got %b want %b", i, glast[i], i == 3); end
    end
  endtask

  task automatic test_stream;
    wds[0] = 64'h0004_0003_0002_0001; wds[1] = 64'h0008_0007_0006_0005; wds[2] = 64'h000C_000B_000A_0009;
    run(3, 0, 0);
    n_cmp += 3;
    if (got.size() != 12) begin n_bad++; $display("FAIL stream_count got %0d want 12", got.size()); end
    if (in_pulses != 3) begin n_bad++; $display("FAIL stream_words got %0d want 3", in_pulses); end
    if (done_cyc != LAT + 12) begin n_bad++; $display("FAIL stream_done got %0d want %0d", done_cyc, LAT + 12); end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_cmp += 3;
      if (got[i] !== 16'(i + 1)) begin n_bad++; $display("FAIL stream_val[%0d] got %h want %h", i, got[i], 16'(i + 1)); end
      if (gcyc[i] != LAT + i) begin n_bad++; $display("FAIL stream_cyc[%0d] got %0d want %0d", i, gcyc[i], LAT + i); end
      if (glast[i] != (i == 11)) begin n_bad++; $display("FAIL stream_last[%0d] got %b want %b", i, glast[i], i == 11); end
    end
  endtask

  task automatic test_backpressure;
    wds[0] = 64'h0004_0003_0002_0001; wds[1] = 64'h0008_0007_0006_0005;
    run(2, 1, 0);
    n_cmp += 4;
    if (got.size() != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got.size()); end
    if (in_pulses != 2) begin n_bad++; $display("FAIL bp_words got %0d want 2", in_pulses); end
    if (viol != 0) begin n_bad++; $display("FAIL bp_in_can_stalled got %0d want 0", viol); end
    if (last_cyc < 0 || done_cyc != last_cyc + 1) begin n_bad++; $display("FAIL bp_done got %0d want %0d", done_cyc, last_cyc + 1); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_cmp += 2;
      if (got[i] !== 16'(i + 1)) begin n_bad++; $display("FAIL bp_val[%0d] got %h want %h", i, got[i], 16'(i + 1)); end
      if (glast[i] != (i == 7)) begin n_bad++; $display("FAIL bp_last[%0d] got %b want %b", i, glast[i], i == 7); end
    end
  endtask

  task automatic test_zero_and_busy;
    run(0, 0, 0);
    n_cmp += 3;
    if (got.size() != 0) begin n_bad++; $display("FAIL zero_count got %0d want 0", got.size()); end
    if (in_pulses != 0) begin n_bad++; $display("FAIL zero_words got %0d want 0", in_pulses); end
    if (done_cyc != 1) begin n_bad++; $display("FAIL zero_idle got %0d want 1", done_cyc); end
    wds[0] = 64'hDDDD_CCCC_BBBB_AAAA;
    run(1, 0, 1);
    n_cmp += 3;
    if (got.size() != 4) begin n_bad++; $display("FAIL busy_count got %0d want 4", got.size()); end
    if (in_pulses != 1) begin n_bad++; $display("FAIL busy_words got %0d want 1", in_pulses); end
    if (got.size() == 4 && got[3] !== 16'hDDDD) begin n_bad++; $display("FAIL busy_tail got %h want dddd", got[3]); end
    @(negedge clk);
    n_cmp++;
    if (in_canReceive !== 1'b0) begin n_bad++; $display("FAIL busy_after got %b want 0", in_canReceive); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int seen = 0, sent = 0, extra = 0;
    wds[0] = 64'h4444_3333_2222_1111; wds[1] = 64'h8888_7777_6666_5555;
    cmd_start = 1; cmd_numWords = 3'd2; out_canReceive = 1;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      #1;
      in_isReady = in_canReceive && sent < 2;
      in_w = wds[sent];
      @(negedge clk);
      if (in_isReady) sent++;
      if (out_isReady) seen++;
      @(posedge clk); #1;
      cmd_start = 0;
    end
    in_isReady = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_cmp += 6;
    if (seen != 2) begin n_bad++; $display("FAIL mrst_pre got %0d want 2", seen); end
    if (cmd_canReceive !== 1'b1) begin n_bad++; $display("FAIL mrst_cmd_can got %b want 1", cmd_canReceive); end
    if (in_canReceive !== 1'b0) begin n_bad++; $display("FAIL mrst_in_can got %b want 0", in_canReceive); end
    if (out_isReady !== 1'b0) begin n_bad++; $display("FAIL mrst_out_rdy got %b want 0", out_isReady); end
    if (out_isLast !== 1'b0) begin n_bad++; $display("FAIL mrst_out_last got %b want 0", out_isLast); end
    if (out_e !== 16'h0) begin n_bad++; $display("FAIL mrst_out got %h want 0000", out_e); end
    repeat (5) begin
      @(negedge clk);
      if (out_isReady || in_canReceive) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL mrst_quiet got %0d want 0", extra); end
    @(posedge clk); #1;
  endtask

`ifdef WORD_UNPACK_BYPASS_EN
  task automatic test_bypass;
    b_cmd_start = 1; b_numWords = 3'd1; b_in = 64'h89AB_CDEF_0123_4567; b_in_isReady = 1;
    @(negedge clk);
    n_cmp += 4;
    if (b_in_can !== 1'b1) begin n_bad++; $display("FAIL byp_in_can got %b want 1", b_in_can); end
    if (b_out_rdy !== 1'b1) begin n_bad++; $display("FAIL byp_rdy0 got %b want 1", b_out_rdy); end
    if (b_out !== 32'h0123_4567) begin n_bad++; $display("FAIL byp_out0 got %h want 01234567", b_out); end
    if (b_out_last !== 1'b0) begin n_bad++; $display("FAIL byp_last0 got %b want 0", b_out_last); end
    @(posedge clk); #1;
    b_cmd_start = 0; b_in_isReady = 0; b_in = '0;
    @(negedge clk);
    n_cmp += 3;
    if (b_out_rdy !== 1'b1) begin n_bad++; $display("FAIL byp_rdy1 got %b want 1", b_out_rdy); end
    if (b_out !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL byp_out1 got %h want 89abcdef", b_out); end
    if (b_out_last !== 1'b1) begin n_bad++; $display("FAIL byp_last1 got %b want 1", b_out_last); end
    @(negedge clk);
    n_cmp++;
    if (b_cmd_can !== 1'b1) begin n_bad++; $display("FAIL byp_done got %b want 1", b_cmd_can); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_zero_and_busy;
    test_mid_reset;
`ifdef WORD_UNPACK_BYPASS_EN
    test_bypass;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
